seg_display_mux: RTL
====================

# seg_display_mux

Parametrised seven-segment display controller for the FPGA board top level. It accepts an N-digit hex value through a valid/ready handshake and commits it only on scan-frame boundaries, so the display never tears. It adds leading-zero blanking, per-digit blink, decimal points and an error override. It drives two outputs from the same state: static per-digit segment buses and a time-multiplexed segment/digit-select pair for boards with a shared segment bus.

## Interface
- NUM_DIGITS, 8, number of digits (1..16)
- ACTIVE_LOW, 1, 1 = segment and digit-select outputs active-low (DE2-115); 0 = active-high
- SCAN_DIV, 50000, clk cycles per digit slot in the multiplexed scan (≥2)
- BLINK_DIV, 32, scan frames per blink half-period (≥1)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- value_i  in  4*NUM_DIGITS  hex value; digit k = value_i[4k+:4], digit 0 rightmost
- valid_i  in  1  value_i/dp_i valid
- ready_o  out  1  block can accept a new value
- dp_i  in  NUM_DIGITS  decimal point per digit, captured with value_i
- lzb_en_i  in  1  leading-zero blanking enable (level, live)
- blink_mask_i  in  NUM_DIGITS  digits to blink (level, live)
- err_i  in  1  error override (level, live)
- segs_o  out  [NUM_DIGITS][8]  static segments per digit; bit7 = dp, bits6:0 = g..a
- seg_mux_o  out  8  multiplexed segment bus
- dig_sel_o  out  NUM_DIGITS  one-hot digit enable for the multiplexed bus
- frame_o  out  1  one-cycle pulse on each scan-frame boundary

## Operation
- Scan timer: prescaler counts 0..SCAN_DIV-1. On each wrap, digit index idx advances 0..NUM_DIGITS-1 and wraps to 0.
- Frame boundary: prescaler wrap while idx == NUM_DIGITS-1.
- Handshake:
  - Transfer on valid_i & ready_o. value_i and dp_i are copied into the pending register, and ready_o drops the next cycle.
  - At the next frame boundary, pending is copied into the shown register and ready_o rises the next cycle.
  - A transfer in the same cycle as a frame boundary commits at the following boundary, not the current one.
  - While ready_o is low, valid_i is ignored and the pending value is never overwritten.
- Blink phase: toggles after every BLINK_DIV frames; reset value 0. When phase is 1, digits with blink_mask_i set are blank (dp included).
- Leading-zero blanking (lzb_en_i = 1):
  - Scan from digit NUM_DIGITS-1 downward; zero digits are blank until the first nonzero digit.
  - Digit 0 is never blanked.
  - A blanked digit still shows its dp if dp is set.
- err_i = 1: every digit shows the error glyph (segments a, d, g). It overrides LZB, blink and dp.
- Glyph priority: err > blink-off > LZB blank > hex glyph | dp.
- Polarity: with ACTIVE_LOW = 1, segs_o, seg_mux_o and dig_sel_o are all inverted. Blank = all segments inactive.
- Multiplexed output:
  - seg_mux_o carries the glyph of digit idx.
  - dig_sel_o has only bit idx active.
  - Both change in the same cycle.

## Timing
- Reset values:
  - segs_o and seg_mux_o: blank (8'hFF when ACTIVE_LOW)
  - dig_sel_o: all inactive
  - ready_o = 1, frame_o = 0
  - shown and pending = 0, prescaler = 0, idx = 0, blink phase = 0
- All outputs are registered. Glyph outputs reflect shown, blink phase, lzb_en_i, blink_mask_i and err_i with exactly one cycle of latency.
- Commit: segs_o shows the new value in the cycle after the frame_o pulse.
- frame_o is registered and high in the cycle after the boundary cycle.
- Reset mid-operation: all state returns to the reset values immediately; any pending value is discarded.
- NUM_DIGITS = 1: every prescaler wrap is a frame boundary.

## Structure
- Package seg_pkg holds:
  - typedef seg_t (logic [7:0])
  - active-high glyph constants SEG_0..SEG_F, SEG_ERR = 8'h49, SEG_BLANK = 8'h00
  - function hex_to_seg
- Polarity is applied only at the output registers.
- Sub-module seg_scan_timer (params SCAN_DIV, NUM_DIGITS): prescaler, idx and the frame-boundary strobe.

## Test plan
All scenarios use NUM_DIGITS = 4, SCAN_DIV = 4, BLINK_DIV = 2, ACTIVE_LOW = 1 (frame = 16 cycles).
- Reset release with no traffic -> segs_o all 8'hC0 from the first cycle after reset; ready_o = 1; dig_sel_o walks 4'hE, D, B, 7, each held 4 cycles.
- valid_i with value 16'h1230 mid-frame -> ready_o low the next cycle; segs_o[3:0] = F9, A4, B0, C0 one cycle after frame_o; ready_o high again.
- Second valid_i (16'hFFFF) while ready_o is low -> ignored; the display and the pending value are unchanged.
- lzb_en_i = 1 with shown 16'h0005 -> segs_o[3:1] = FF, segs_o[0] = 8'h92. Shown 16'h0000 -> only digit 0 shows C0.
- blink_mask_i = 4'b0001 -> segs_o[0] alternates glyph and FF every 2 frames; other digits are steady.
- err_i pulse for 3 cycles during a pending commit -> all digits = 8'hB6 for exactly 3 cycles (1-cycle delay); the commit still completes. Async reset asserted mid-frame -> all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment types, active-high glyph constants and the hex decoder.
// Bit 7 is the decimal point; bits 6:0 are segments g..a.
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_0     = 8'h3F;
    localparam seg_t SEG_1     = 8'h06;
    localparam seg_t SEG_2     = 8'h5B;
    localparam seg_t SEG_3     = 8'h4F;
    localparam seg_t SEG_4     = 8'h66;
    localparam seg_t SEG_5     = 8'h6D;
    localparam seg_t SEG_6     = 8'h7D;
    localparam seg_t SEG_7     = 8'h07;
    localparam seg_t SEG_8     = 8'h7F;
    localparam seg_t SEG_9     = 8'h6F;
    localparam seg_t SEG_A     = 8'h77;
    localparam seg_t SEG_B     = 8'h7C;
    localparam seg_t SEG_C     = 8'h39;
    localparam seg_t SEG_D     = 8'h5E;
    localparam seg_t SEG_E     = 8'h79;
    localparam seg_t SEG_F     = 8'h71;
    localparam seg_t SEG_ERR   = 8'h49;
    localparam seg_t SEG_BLANK = 8'h00;
    localparam seg_t SEG_DP    = 8'h80;

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        case (hex)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Value handshake, live display controls and both display output styles.
// The slave side is the display controller; the master side is the value producer.
interface seg_display_mux_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_i;
    logic                    valid_i;
    logic                    ready_o;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic                    lzb_en_i;
    logic [NUM_DIGITS-1:0]   blink_mask_i;
    logic                    err_i;
    seg_t [NUM_DIGITS-1:0]   segs_o;
    seg_t                    seg_mux_o;
    logic [NUM_DIGITS-1:0]   dig_sel_o;
    logic                    frame_o;

    modport master (
        output value_i, valid_i, dp_i, lzb_en_i, blink_mask_i, err_i,
        input  ready_o, segs_o, seg_mux_o, dig_sel_o, frame_o
    );

    modport slave (
        input  value_i, valid_i, dp_i, lzb_en_i, blink_mask_i, err_i,
        output ready_o, segs_o, seg_mux_o, dig_sel_o, frame_o
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Digit-slot prescaler and scan index; boundary is combinational from the counters,
// asserted in the last cycle of the last digit slot of each frame.
module seg_scan_timer #(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = 8,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             boundary
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc;
    logic          wrap;
    logic          last_digit;

    assign wrap       = (presc == PW'(SCAN_DIV - 1));
    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign boundary   = wrap && last_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (wrap) begin
            presc <= '0;
            idx   <= last_digit ? '0 : idx + IDX_W'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/seg_display_mux.sv
// Seven-segment controller: frame-synchronous value commit, LZB, blink, dp, error glyph.
// Static and multiplexed outputs are registered, one cycle behind the live state.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    seg_display_mux_if.slave   bus
);
    localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int   BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic AL    = (ACTIVE_LOW != 0);
    localparam seg_t POL   = AL ? 8'hFF : 8'h00;
    localparam logic [8*NUM_DIGITS-1:0] POL_ALL = {NUM_DIGITS{POL}};

    logic [IDX_W-1:0]        idx;
    logic                    boundary;
    logic [4*NUM_DIGITS-1:0] pend_val, shown_val;
    logic [NUM_DIGITS-1:0]   pend_dp, shown_dp;
    logic                    ready_q;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    seg_t [NUM_DIGITS-1:0]   glyph;
    logic [3:0]              digit;
    logic                    nz_above;
    logic                    lz_blank;
    seg_t                    dp_seg;

    seg_scan_timer #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W)
    ) u_scan (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .idx      (idx),
        .boundary (boundary)
    );

    assign bus.ready_o = ready_q;

    // A full pending slot (ready low) is the only thing a boundary commits, so a
    // transfer landing on a boundary cycle waits for the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_val  <= '0;
            pend_dp   <= '0;
            shown_val <= '0;
            shown_dp  <= '0;
            ready_q   <= 1'b1;
        end else if (boundary && !ready_q) begin
            shown_val <= pend_val;
            shown_dp  <= pend_dp;
            ready_q   <= 1'b1;
        end else if (ready_q && bus.valid_i) begin
            pend_val  <= bus.value_i;
            pend_dp   <= bus.dp_i;
            ready_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        glyph    = '0;
        digit    = '0;
        nz_above = 1'b0;
        lz_blank = 1'b0;
        dp_seg   = SEG_BLANK;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            digit    = shown_val[4*k +: 4];
            dp_seg   = shown_dp[k] ? SEG_DP : SEG_BLANK;
            lz_blank = bus.lzb_en_i && (k != 0) && !nz_above && (digit == 4'h0);
            if (digit != 4'h0)
                nz_above = 1'b1;
            if (bus.err_i)
                glyph[k] = SEG_ERR;
            else if (blink_phase && bus.blink_mask_i[k])
                glyph[k] = SEG_BLANK;
            else if (lz_blank)
                glyph[k] = dp_seg;
            else
                glyph[k] = hex_to_seg(digit) | dp_seg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.segs_o    <= POL_ALL;
            bus.seg_mux_o <= POL;
            bus.dig_sel_o <= {NUM_DIGITS{AL}};
            bus.frame_o   <= 1'b0;
        end else begin
            bus.segs_o    <= glyph ^ POL_ALL;
            bus.seg_mux_o <= glyph[idx] ^ POL;
            bus.dig_sel_o <= (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{AL}};
            bus.frame_o   <= boundary;
        end
    end

endmodule
